// File: rtl/serv_pkg.sv
// Shared definitions for the serv sequencer blocks.
//   state_t        : sequencer state encoding
//   WORD_LEN       : number of bit-serial cycles in one data word
//   CNT_W/CNT_LAST : bit counter width and its terminal value
//   is_misaligned  : alignment rule for half/word accesses
package serv_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_SHIFT = 3'd2,
        S_BUS   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int WORD_LEN = 32;
    localparam int CNT_W    = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_LEN - 1);

    // Word accesses need both address LSBs clear, half accesses only bit 0.
    // Byte accesses are always aligned.
    function automatic logic is_misaligned(input logic half,
                                           input logic word,
                                           input logic [1:0] lsb);
        if (word)
            return (lsb != 2'b00);
        else
            return (half & lsb[0]);
    endfunction

endpackage

// File: rtl/serv_seq_cnt.sv
// 5-bit bit counter for the serv sequencer.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clr        : synchronous clear to 0 (wins over i_inc)
//   i_inc        : increment by one, wrapping 31 -> 0
//   i_cmp        : value to compare the counter against
//   o_cnt        : current count
//   o_tc         : count is at the last bit of a word
//   o_match      : count equals i_cmp
module serv_seq_cnt
    import serv_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_cmp,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc,
    output logic             o_match
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            cnt_reg <= '0;
        else if (i_clr)
            cnt_reg <= '0;
        else if (i_inc)
            cnt_reg <= cnt_reg + 1'b1;
    end

    assign o_cnt   = cnt_reg;
    assign o_tc    = (cnt_reg == CNT_LAST);
    assign o_match = (cnt_reg == i_cmp);

endmodule

// File: rtl/serv_bufreg_seq.sv
// Sequencer for the serv buffer register: runs a 32-cycle init pass, then
// either a shift pass of shamt cycles or a data-bus access, then a one-cycle
// done/trap status.
//   i_clk, i_rst         : clock, asynchronous active-high reset
//   i_req                : start strobe (only looked at in IDLE)
//   i_mem_op, i_we       : load/store vs shift, store direction
//   i_shamt              : shift amount
//   i_half, i_word       : access size
//   i_lsb                : address LSBs from the buffer register
//   i_dbus_ack           : data-bus completion
//   o_en, o_init         : buffer-register enable / init phase
//   o_cnt0, o_cnt1       : first / second init cycle markers
//   o_dbus_cyc, o_dbus_we: data-bus request and direction
//   o_busy, o_done, o_trap: status
module serv_bufreg_seq
    import serv_pkg::*;
#(
    parameter int ALIGN_CHK = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req,
    input  logic       i_mem_op,
    input  logic       i_we,
    input  logic [4:0] i_shamt,
    input  logic       i_half,
    input  logic       i_word,
    input  logic [1:0] i_lsb,
    input  logic       i_dbus_ack,
    output logic       o_en,
    output logic       o_init,
    output logic       o_cnt0,
    output logic       o_cnt1,
    output logic       o_dbus_cyc,
    output logic       o_dbus_we,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_trap
);

    state_t state_reg, state_next;

    logic             mem_reg, we_reg, half_reg, word_reg;
    logic [4:0]       shamt_reg;
    logic             cyc_reg, trap_reg;

    logic             cnt_clr, cnt_inc, cnt_tc, cnt_match;
    logic [CNT_W-1:0] cnt;

    logic             accept, misaligned, cyc_set, cyc_clr, trap_set;

    // Shift exits on the last of shamt cycles. shamt is never 0 in SHIFT, so
    // the subtraction cannot underflow and the counter never wraps there.
    serv_seq_cnt u_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (cnt_clr),
        .i_inc   (cnt_inc),
        .i_cmp   (shamt_reg - 5'd1),
        .o_cnt   (cnt),
        .o_tc    (cnt_tc),
        .o_match (cnt_match)
    );

    assign accept     = (state_reg == S_IDLE) && i_req;
    assign misaligned = (ALIGN_CHK != 0) && is_misaligned(half_reg, word_reg, i_lsb);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // The first BUS cycle (cyc still low) is where i_lsb is judged; only an
    // aligned access raises the bus request, so a trapped access never
    // touches the bus.
    always_comb begin
        state_next = state_reg;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        cyc_set    = 1'b0;
        cyc_clr    = 1'b0;
        trap_set   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (i_req) begin
                    state_next = S_INIT;
                    cnt_clr    = 1'b1;
                end
            end
            S_INIT: begin
                cnt_inc = 1'b1;
                if (cnt_tc) begin
                    if (mem_reg)
                        state_next = S_BUS;
                    else if (shamt_reg == 5'd0)
                        state_next = S_DONE;
                    else
                        state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                cnt_inc = 1'b1;
                if (cnt_match)
                    state_next = S_DONE;
            end
            S_BUS: begin
                if (!cyc_reg) begin
                    if (misaligned) begin
                        trap_set   = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        cyc_set = 1'b1;
                    end
                end else if (i_dbus_ack) begin
                    cyc_clr    = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                cnt_clr    = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem_reg   <= 1'b0;
            we_reg    <= 1'b0;
            half_reg  <= 1'b0;
            word_reg  <= 1'b0;
            shamt_reg <= 5'd0;
            trap_reg  <= 1'b0;
            cyc_reg   <= 1'b0;
        end else begin
            if (accept) begin
                mem_reg   <= i_mem_op;
                we_reg    <= i_we;
                half_reg  <= i_half;
                word_reg  <= i_word;
                shamt_reg <= i_shamt;
                trap_reg  <= 1'b0;
            end else if (trap_set) begin
                trap_reg <= 1'b1;
            end
            if (cyc_set)
                cyc_reg <= 1'b1;
            else if (cyc_clr)
                cyc_reg <= 1'b0;
        end
    end

    assign o_en       = (state_reg == S_INIT) || (state_reg == S_SHIFT);
    assign o_init     = (state_reg == S_INIT);
    assign o_cnt0     = (state_reg == S_INIT) && (cnt == 5'd0);
    assign o_cnt1     = (state_reg == S_INIT) && (cnt == 5'd1);
    assign o_dbus_cyc = cyc_reg;
    assign o_dbus_we  = (state_reg == S_BUS) && we_reg;
    assign o_busy     = (state_reg != S_IDLE);
    assign o_done     = (state_reg == S_DONE);
    assign o_trap     = (state_reg == S_DONE) && trap_reg;

endmodule

// File: tb/tb_serv_bufreg_seq.sv
// Randomized bench for serv_bufreg_seq. Two instances run in lockstep on the
// same stimulus, one with the alignment check and one without; each has its
// own ack line. For every transaction a per-cycle list of expected outputs
// is built from the operation description and compared cycle by cycle.
module tb_serv_bufreg_seq;

    // Expected-output vector bit order:
    // [8]en [7]init [6]cnt0 [5]cnt1 [4]cyc [3]we [2]busy [1]done [0]trap
    typedef struct packed {
        logic [8:0] v;
        logic       bus;
        logic       ack;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       mem_op = 1'b0;
    logic       we = 1'b0;
    logic [4:0] shamt = 5'd0;
    logic       half = 1'b0;
    logic       word = 1'b0;
    logic [1:0] lsb = 2'd0;
    logic       ack0 = 1'b0;
    logic       ack1 = 1'b0;

    logic [8:0] obs0, obs1;
    logic en0, init0, c00, c10, cyc0, we0, busy0, done0, trap0;
    logic en1, init1, c01, c11, cyc1, we1, busy1, done1, trap1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    ent_t q0[$];
    ent_t q1[$];

    always #5 clk = ~clk;

    serv_bufreg_seq #(.ALIGN_CHK(1)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_mem_op(mem_op), .i_we(we),
        .i_shamt(shamt), .i_half(half), .i_word(word), .i_lsb(lsb),
        .i_dbus_ack(ack0),
        .o_en(en0), .o_init(init0), .o_cnt0(c00), .o_cnt1(c10),
        .o_dbus_cyc(cyc0), .o_dbus_we(we0), .o_busy(busy0),
        .o_done(done0), .o_trap(trap0)
    );

    serv_bufreg_seq #(.ALIGN_CHK(0)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_mem_op(mem_op), .i_we(we),
        .i_shamt(shamt), .i_half(half), .i_word(word), .i_lsb(lsb),
        .i_dbus_ack(ack1),
        .o_en(en1), .o_init(init1), .o_cnt0(c01), .o_cnt1(c11),
        .o_dbus_cyc(cyc1), .o_dbus_we(we1), .o_busy(busy1),
        .o_done(done1), .o_trap(trap1)
    );

    assign obs0 = {en0, init0, c00, c10, cyc0, we0, busy0, done0, trap0};
    assign obs1 = {en1, init1, c01, c11, cyc1, we1, busy1, done1, trap1};

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic push(input bit sel, input logic [8:0] v, input logic bus, input logic a);
        ent_t e;
        e.v = v; e.bus = bus; e.ack = a;
        if (sel) q1.push_back(e); else q0.push_back(e);
    endtask

    // Expected behaviour of one transaction, one entry per cycle starting
    // with the cycle after the request is accepted. size: 0 byte, 1 half, 2 word.
    // w = number of cycles the bus request stays up (ack in the last one).
    task automatic build(input bit sel, input bit align, input bit m, input bit st,
                         input int sh, input int size, input int l, input int w);
        bit mis;
        for (int i = 0; i < 32; i++)
            push(sel, {1'b1, 1'b1, (i == 0), (i == 1), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b0, 1'b0);
        if (!m) begin
            for (int i = 0; i < sh; i++)
                push(sel, 9'b1_0000_0100, 1'b0, 1'b0);
            push(sel, 9'b0_0000_0110, 1'b0, 1'b0);
        end else begin
            if (size == 2)      mis = (l != 0);
            else if (size == 1) mis = (l % 2 == 1);
            else                mis = 1'b0;
            mis = mis && align;
            // Alignment-check cycle: in BUS, no request yet.
            push(sel, {4'b0000, 1'b0, st, 1'b1, 2'b00}, 1'b1, 1'b0);
            if (mis) begin
                push(sel, 9'b0_0000_0111, 1'b0, 1'b0);
            end else begin
                for (int k = 1; k <= w; k++)
                    push(sel, {4'b0000, 1'b1, st, 1'b1, 2'b00}, 1'b1, (k == w));
                push(sel, 9'b0_0000_0110, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic run_txn(input bit m, input bit st, input int sh, input int size,
                           input int l, input int w, input bit extra);
        int len;
        q0.delete();
        q1.delete();
        build(1'b0, 1'b1, m, st, sh, size, l, w);
        build(1'b1, 1'b0, m, st, sh, size, l, w);
        len = (q0.size() > q1.size()) ? q0.size() : q1.size();
        @(negedge clk);
        check($sformatf("t%0d idle0", n_txn), obs0, 9'd0);
        check($sformatf("t%0d idle1", n_txn), obs1, 9'd0);
        req    = 1'b1;
        mem_op = m;
        we     = st;
        shamt  = 5'(sh);
        half   = (size == 1);
        word   = (size == 2);
        lsb    = 2'(l);
        ack0   = 1'b0;
        ack1   = 1'b0;
        for (int idx = 0; idx < len; idx++) begin
            @(negedge clk);
            if (idx < q0.size()) check($sformatf("t%0d d0 c%0d", n_txn, idx), obs0, q0[idx].v);
            else                 check($sformatf("t%0d d0 c%0d", n_txn, idx), obs0, 9'd0);
            if (idx < q1.size()) check($sformatf("t%0d d1 c%0d", n_txn, idx), obs1, q1[idx].v);
            else                 check($sformatf("t%0d d1 c%0d", n_txn, idx), obs1, 9'd0);
            req = (extra && idx <= 31) ? 1'($urandom % 2) : 1'b0;
            if (idx < q0.size() && q0[idx].bus) ack0 = q0[idx].ack;
            else                                ack0 = 1'($urandom % 2);
            if (idx < q1.size() && q1[idx].bus) ack1 = q1[idx].ack;
            else                                ack1 = 1'($urandom % 2);
        end
        @(negedge clk);
        check($sformatf("t%0d end0", n_txn), obs0, 9'd0);
        check($sformatf("t%0d end1", n_txn), obs1, 9'd0);
        ack0 = 1'b0;
        ack1 = 1'b0;
        $display("txn %0d: mem=%0d we=%0d shamt=%0d size=%0d lsb=%0d wait=%0d extra=%0d cycles0=%0d cycles1=%0d",
                 n_txn, m, st, sh, size, l, w, extra, q0.size(), q1.size());
        n_txn++;
    endtask

    // Start an aligned word load, never ack it, and pull reset while the
    // bus request is up.
    task automatic reset_mid_bus();
        bit found = 1'b0;
        @(negedge clk);
        req = 1'b1; mem_op = 1'b1; we = 1'b0; half = 1'b0; word = 1'b1; lsb = 2'd0;
        ack0 = 1'b0; ack1 = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            req = 1'b0;
            if (cyc0 === 1'b1) found = 1'b1;
        end
        check("rst cyc seen", {8'd0, found}, 9'd1);
        #2 rst = 1'b1;
        #1;
        check("rst async d0", obs0, 9'd0);
        check("rst async d1", obs1, 9'd0);
        @(negedge clk);
        check("rst held d0", obs0, 9'd0);
        rst = 1'b0;
        $display("txn %0d: reset asserted during bus cycle", n_txn);
        n_txn++;
    endtask

    initial begin
        #1;
        check("reset d0", obs0, 9'd0);
        check("reset d1", obs1, 9'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_txn(1'b0, 1'b0, 5, 2, 0, 1, 1'b0);  // shift by 5
        run_txn(1'b1, 1'b0, 0, 2, 0, 3, 1'b0);  // word load, ack in 3rd cyc cycle
        run_txn(1'b1, 1'b1, 0, 1, 1, 2, 1'b0);  // misaligned half store
        run_txn(1'b0, 1'b0, 0, 0, 0, 1, 1'b1);  // shamt=0 with extra req pulses
        run_txn(1'b0, 1'b0, 31, 0, 0, 1, 1'b0); // longest shift
        run_txn(1'b1, 1'b1, 0, 2, 2, 1, 1'b0);  // misaligned word store
        reset_mid_bus();
        run_txn(1'b0, 1'b0, 1, 0, 0, 1, 1'b0);  // clean start after reset

        for (int t = 0; t < 30; t++)
            run_txn(1'($urandom % 2), 1'($urandom % 2), int'($urandom % 32),
                    int'($urandom % 3), int'($urandom % 4), 1 + int'($urandom % 4),
                    1'($urandom % 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
